mig_app_arbiter: RTL and testbench

MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

---
 rtl/mig_app_arbiter_if.sv | 43 ++++
 rtl/mig_app_arbiter.sv | 123 ++++++++++++
 tb/tb_mig_app_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_app_arbiter_if.sv
// rtl/mig_app_arbiter_if.sv - requester, MIG app and status signals of the MIG app arbiter
interface mig_app_arbiter_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256
);
  logic                  init_calib_complete;
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_ack;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  app_en;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [2:0]            app_cmd;
  logic [ADDR_W-1:0]     app_addr;
  logic [DATA_W-1:0]     app_wdf_data;
  logic [DATA_W/8-1:0]   app_wdf_mask;
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic                  app_rd_data_valid;
  logic [DATA_W-1:0]     app_rd_data;
  logic                  busy;
  logic [4:0]            rd_outstanding;

  modport slave (
    input  init_calib_complete, wr_req, wr_addr, wr_data, rd_req, rd_addr,
           app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    output wr_ack, rd_ack, rd_data, rd_valid, app_en, app_wdf_wren, app_wdf_end,
           app_cmd, app_addr, app_wdf_data, app_wdf_mask, busy, rd_outstanding
  );

  modport master (
    output init_calib_complete, wr_req, wr_addr, wr_data, rd_req, rd_addr,
           app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    input  wr_ack, rd_ack, rd_data, rd_valid, app_en, app_wdf_wren, app_wdf_end,
           app_cmd, app_addr, app_wdf_data, app_wdf_mask, busy, rd_outstanding
  );
endinterface

// File: rtl/mig_app_arbiter.sv
// rtl/mig_app_arbiter.sv - round-robin write/read arbiter in front of a MIG app port
module mig_app_arbiter #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int MAX_RD_OUT = 16
) (
  input  logic           ui_clk,
  input  logic           sys_rst,
  mig_app_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR, ST_RD} state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_RD_OUT);

  state_t              state, state_nxt;
  logic                last_grant_wr;
  logic                grant_wr, grant_rd;
  logic                wr_done, rd_done, rd_elig;
  logic                app_en_q, app_wdf_wren_q, app_wdf_end_q;
  logic [2:0]          app_cmd_q;
  logic [ADDR_W-1:0]   app_addr_q;
  logic [DATA_W-1:0]   app_wdf_data_q;
  logic                wr_ack_q, rd_ack_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [4:0]          rd_cnt_q;

  assign wr_done = (state == ST_WR) && bus.app_rdy && bus.app_wdf_rdy;
  assign rd_done = (state == ST_RD) && bus.app_rdy;
  assign rd_elig = bus.rd_req && (rd_cnt_q < MAX_CNT);

  // Calibration loss in IDLE wins over any pending request
  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      ST_INIT: if (bus.init_calib_complete) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (!bus.init_calib_complete) begin
          state_nxt = ST_INIT;
        end else if (bus.wr_req && rd_elig) begin
          grant_rd = last_grant_wr;
          grant_wr = !last_grant_wr;
        end else begin
          grant_wr = bus.wr_req;
          grant_rd = rd_elig;
        end
        if (grant_wr) state_nxt = ST_WR;
        if (grant_rd) state_nxt = ST_RD;
      end
      ST_WR:   if (wr_done) state_nxt = ST_IDLE;
      ST_RD:   if (rd_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (!sys_rst) begin
      state          <= ST_INIT;
      last_grant_wr  <= 1'b1;
      app_en_q       <= 1'b0;
      app_wdf_wren_q <= 1'b0;
      app_wdf_end_q  <= 1'b0;
      app_cmd_q      <= 3'b000;
      app_addr_q     <= '0;
      app_wdf_data_q <= '0;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_cnt_q       <= 5'd0;
    end else begin
      state      <= state_nxt;
      wr_ack_q   <= wr_done;
      rd_ack_q   <= rd_done;
      rd_valid_q <= bus.app_rd_data_valid;
      rd_data_q  <= bus.app_rd_data;
      if (grant_wr) begin
        app_en_q       <= 1'b1;
        app_wdf_wren_q <= 1'b1;
        app_wdf_end_q  <= 1'b1;
        app_cmd_q      <= 3'b000;
        app_addr_q     <= bus.wr_addr;
        app_wdf_data_q <= bus.wr_data;
        last_grant_wr  <= 1'b1;
      end else if (grant_rd) begin
        app_en_q       <= 1'b1;
        app_wdf_wren_q <= 1'b0;
        app_wdf_end_q  <= 1'b0;
        app_cmd_q      <= 3'b001;
        app_addr_q     <= bus.rd_addr;
        last_grant_wr  <= 1'b0;
      end else if (wr_done || rd_done) begin
        app_en_q       <= 1'b0;
        app_wdf_wren_q <= 1'b0;
        app_wdf_end_q  <= 1'b0;
      end
      // Accept and return in the same cycle cancel; a stray return never wraps below zero
      if (rd_done && !bus.app_rd_data_valid) begin
        rd_cnt_q <= rd_cnt_q + 5'd1;
      end else if (!rd_done && bus.app_rd_data_valid && (rd_cnt_q != 5'd0)) begin
        rd_cnt_q <= rd_cnt_q - 5'd1;
      end
    end
  end

  assign bus.app_en         = app_en_q;
  assign bus.app_wdf_wren   = app_wdf_wren_q;
  assign bus.app_wdf_end    = app_wdf_end_q;
  assign bus.app_cmd        = app_cmd_q;
  assign bus.app_addr       = app_addr_q;
  assign bus.app_wdf_data   = app_wdf_data_q;
  assign bus.app_wdf_mask   = '0;
  assign bus.wr_ack         = wr_ack_q;
  assign bus.rd_ack         = rd_ack_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_outstanding = rd_cnt_q;
  assign bus.busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_mig_app_arbiter.sv
// tb/tb_mig_app_arbiter.sv - directed scoreboard bench for mig_app_arbiter
module tb_mig_app_arbiter;
  localparam int ADDR_W = 29;
  localparam int DATA_W = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mig_app_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mig_app_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD_OUT(16)) dut (
    .ui_clk (clk),
    .sys_rst(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t              cmd_q[$];
  logic [DATA_W-1:0] rd_q[$];
  cmd_t              mon_e;
  logic [DATA_W-1:0] mon_d;
  int                n_chk = 0;
  int                n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_t e;
    e.cmd  = c;
    e.addr = a;
    e.data = d;
    cmd_q.push_back(e);
  endtask

  task automatic ret_data(input logic [DATA_W-1:0] d);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = d;
    rd_q.push_back(d);
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
  endtask

  task automatic wait_ack(input bit is_wr, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_wr ? bus.wr_ack : bus.rd_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  task automatic wait_en(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.app_en) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_app_en"},       bus.app_en, 0);
    chk({tag, "_app_wdf_wren"}, bus.app_wdf_wren, 0);
    chk({tag, "_app_wdf_end"},  bus.app_wdf_end, 0);
    chk({tag, "_app_cmd"},      bus.app_cmd, 0);
    chk({tag, "_app_addr"},     bus.app_addr, 0);
    chk({tag, "_app_wdf_data"}, bus.app_wdf_data, 0);
    chk({tag, "_app_wdf_mask"}, bus.app_wdf_mask, 0);
    chk({tag, "_wr_ack"},       bus.wr_ack, 0);
    chk({tag, "_rd_ack"},       bus.rd_ack, 0);
    chk({tag, "_rd_valid"},     bus.rd_valid, 0);
    chk({tag, "_rd_data"},      bus.rd_data, 0);
    chk({tag, "_rd_out"},       bus.rd_outstanding, 0);
    chk({tag, "_busy"},         bus.busy, 1);
  endtask

  // Scoreboard: each ack retires the oldest expected command, each rd_valid the oldest expected data
  always @(negedge clk) begin
    if (bus.wr_ack || bus.rd_ack) begin
      if (cmd_q.size() == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        mon_e = cmd_q.pop_front();
        chk("ack_cmd",  bus.app_cmd, mon_e.cmd);
        chk("ack_kind", bus.rd_ack, (mon_e.cmd == 3'b001));
        chk("ack_addr", bus.app_addr, mon_e.addr);
        if (mon_e.cmd == 3'b000) chk("ack_wdata", bus.app_wdf_data, mon_e.data);
      end
    end
    if (bus.rd_valid) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        mon_d = rd_q.pop_front();
        chk("rd_data", bus.rd_data, mon_d);
      end
    end
  end

  initial begin
    rst_n                   = 1'b0;
    bus.init_calib_complete = 1'b0;
    bus.wr_req              = 1'b0;
    bus.wr_addr             = '0;
    bus.wr_data             = '0;
    bus.rd_req              = 1'b0;
    bus.rd_addr             = '0;
    bus.app_rdy             = 1'b0;
    bus.app_wdf_rdy         = 1'b0;
    bus.app_rd_data_valid   = 1'b0;
    bus.app_rd_data         = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // Calibration gate
    rst_n           = 1'b1;
    bus.app_rdy     = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    bus.wr_addr     = 29'h10;
    bus.wr_data     = 256'h1;
    bus.wr_req      = 1'b1;
    push_cmd(3'b000, 29'h10, 256'h1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("calib_gate_en", bus.app_en, 0);
    end
    chk("calib_gate_busy", bus.busy, 1);
    bus.init_calib_complete = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.app_en) break;
    end
    chk("calib_en_3cyc", bus.app_en, 1);
    chk("calib_cmd", bus.app_cmd, 3'b000);
    wait_ack(1'b1, "calib_wr_ack");
    bus.wr_req = 1'b0;
    @(negedge clk);

    // Write backpressure on app_wdf_rdy
    bus.app_wdf_rdy = 1'b0;
    bus.wr_addr     = 29'h8;
    bus.wr_data     = 256'h2;
    bus.wr_req      = 1'b1;
    push_cmd(3'b000, 29'h8, 256'h2);
    wait_en("bp_en");
    for (int i = 0; i < 10; i++) begin
      chk("bp_app_en", bus.app_en, 1);
      chk("bp_wren",   bus.app_wdf_wren, 1);
      chk("bp_end",    bus.app_wdf_end, 1);
      chk("bp_addr",   bus.app_addr, 29'h8);
      chk("bp_data",   bus.app_wdf_data, 256'h2);
      chk("bp_no_ack", bus.wr_ack, 0);
      @(negedge clk);
    end
    bus.app_wdf_rdy = 1'b1;
    wait_ack(1'b1, "bp_ack");
    bus.wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_single_ack", bus.wr_ack, 0);
    end

    // Round-robin with both requesters held high; read wins first
    bus.wr_addr = 29'h100;
    bus.wr_data = 256'hAA;
    bus.rd_addr = 29'h200;
    push_cmd(3'b001, 29'h200, '0);
    push_cmd(3'b000, 29'h100, 256'hAA);
    push_cmd(3'b001, 29'h200, '0);
    push_cmd(3'b000, 29'h100, 256'hAA);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    begin
      int acks = 0;
      for (int i = 0; i < 40 && acks < 4; i++) begin
        @(negedge clk);
        if (bus.wr_ack || bus.rd_ack) acks++;
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      chk("rr_ack_count", acks, 4);
    end
    @(negedge clk);
    chk("rr_outstanding", bus.rd_outstanding, 2);
    ret_data(256'h1111);
    ret_data(256'h2222);
    chk("drain_outstanding", bus.rd_outstanding, 0);
    ret_data(256'h3333);
    chk("stray_saturate", bus.rd_outstanding, 0);

    // Outstanding-read limit
    bus.rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 29'h1000 + 29'(8 * i);
      push_cmd(3'b001, bus.rd_addr, '0);
      wait_ack(1'b0, "lim_ack");
    end
    bus.rd_addr = 29'h1080;
    push_cmd(3'b001, 29'h1080, '0);
    chk("lim_count16", bus.rd_outstanding, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lim_no_issue", bus.app_en, 0);
    end
    ret_data(256'h4444);
    wait_ack(1'b0, "lim_17th_ack");
    chk("lim_count_again", bus.rd_outstanding, 16);
    bus.rd_req = 1'b0;

    // Read accept coinciding with returned data
    ret_data(256'h5555);
    bus.rd_addr = 29'h1088;
    push_cmd(3'b001, 29'h1088, '0);
    bus.rd_req = 1'b1;
    wait_en("sim_en");
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = 256'h6666;
    rd_q.push_back(256'h6666);
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    bus.rd_req            = 1'b0;
    chk("sim_rd_ack", bus.rd_ack, 1);
    chk("sim_outstanding", bus.rd_outstanding, 15);
    chk("sim_rd_valid", bus.rd_valid, 1);
    for (int i = 0; i < 15; i++) ret_data(256'h9000 + 256'(i));
    chk("final_drain", bus.rd_outstanding, 0);

    // Reset while a write is stalled
    bus.app_rdy = 1'b0;
    bus.wr_addr = 29'h40;
    bus.wr_data = 256'h5;
    bus.wr_req  = 1'b1;
    wait_en("midrst_en");
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.app_rdy = 1'b1;
    ret_data(256'h7777);
    chk("post_rst_rd_valid", bus.rd_valid, 1);
    chk("post_rst_outstanding", bus.rd_outstanding, 0);
    repeat (3) @(negedge clk);

    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
